// File: rtl/bo_buffer_loader_if.sv
// Word-serial bias stream handshake for bo_buffer_loader.
interface bo_buffer_loader_if #(
  parameter int unsigned D_WL = 24
);
  logic            in_valid;
  logic [D_WL-1:0] in_data;
  logic            in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/bo_buffer_loader.sv
// Runtime-loadable output-gate bias table: packs UNITS_NUM scalars per row into DEPTH rows.
// Optional BO_RD_REG_EN registers the read port (one cycle of read latency).
module bo_buffer_loader #(
  parameter int unsigned D_WL      = 24,
  parameter int unsigned UNITS_NUM = 5,
  parameter int unsigned DEPTH     = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  bo_buffer_loader_if.slave         sif,
  output logic                      busy,
  output logic                      done,
  output logic                      loaded,
  input  logic [7:0]                addr,
  output logic [UNITS_NUM*D_WL-1:0] w_o
);

  localparam int unsigned W  = UNITS_NUM * D_WL;
  localparam int unsigned SW = (UNITS_NUM > 1) ? $clog2(UNITS_NUM) : 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {StIdle, StLoad} state_e;

  state_e          state_q;
  logic [W-1:0]    pack_q;
  logic [SW-1:0]   slot_q;
  logic [AW-1:0]   row_q;
  logic            done_q;
  logic            loaded_q;
  logic [W-1:0]    rows_q [DEPTH];

  logic            beat;
  logic            last_slot;
  logic            last_row;
  logic [W-1:0]    pack_nxt;
  logic [W-1:0]    rd_row;

  assign busy         = (state_q == StLoad);
  assign sif.in_ready = busy;
  assign done         = done_q;
  assign loaded       = loaded_q;

  assign beat      = sif.in_valid && busy;
  assign last_slot = (slot_q == SW'(UNITS_NUM - 1));
  assign last_row  = (row_q == AW'(DEPTH - 1));
  // First scalar of a row drifts up to the MSB slice, matching ROM literal order.
  assign pack_nxt  = (pack_q << D_WL) | W'(sif.in_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pack_q   <= '0;
      slot_q   <= '0;
      row_q    <= '0;
      done_q   <= 1'b0;
      loaded_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) rows_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        // A coinciding final beat still lands its row; any other beat is dropped.
        if (beat && last_slot && last_row) rows_q[row_q] <= pack_nxt;
        state_q  <= StLoad;
        pack_q   <= '0;
        slot_q   <= '0;
        row_q    <= '0;
        loaded_q <= 1'b0;
      end else if (beat) begin
        if (last_slot) begin
          rows_q[row_q] <= pack_nxt;
          pack_q        <= '0;
          slot_q        <= '0;
          if (last_row) begin
            row_q    <= '0;
            state_q  <= StIdle;
            done_q   <= 1'b1;
            loaded_q <= 1'b1;
          end else begin
            row_q <= row_q + AW'(1);
          end
        end else begin
          pack_q <= pack_nxt;
          slot_q <= slot_q + SW'(1);
        end
      end
    end
  end

  always_comb begin
    rd_row = '0;
    if (32'(addr) < DEPTH) rd_row = rows_q[addr[AW-1:0]];
  end

`ifdef BO_RD_REG_EN
  logic [W-1:0] rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= rd_row;
  end

  assign w_o = rd_q;
`else
  assign w_o = rd_row;
`endif

endmodule

// File: doc/bo_buffer_loader.md
Name: bo_buffer_loader

Overview:
Writable counterpart of the output-gate bias ROM. Accepts a word-serial stream of D_WL-bit bias scalars over a valid/ready handshake and packs UNITS_NUM scalars into one row. Writes DEPTH rows into an internal register file. Exposes the same addr -> w_o read interface the LSTM datapath already consumes, so biases can be reloaded at runtime instead of being fixed at synthesis.

Parameters:
D_WL, 24, bit width of one bias scalar (two's complement)
UNITS_NUM, 5, scalars packed per row
DEPTH, 6, number of rows (timesteps/gate rows); must be 1..256

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins (or restarts) a load sequence at row 0, slot 0
in_valid  input  1  in_data valid
in_data  input  D_WL  bias scalar
in_ready  output  1  loader can accept a scalar; equals busy
busy  output  1  load sequence in progress
done  output  1  one-cycle pulse after the last row is written
loaded  output  1  level; high once a full load completes, cleared by start
addr  input  8  read row index
w_o  output  UNITS_NUM*D_WL  packed row at addr

Behaviour:
- Async reset (rst_n=0): all rows=0, pack register=0, slot_cnt=0, row_cnt=0, busy=0, in_ready=0, done=0, loaded=0. Reset mid-load abandons the load and zeroes every row.
- FSM states:
  - IDLE: start -> LOAD; clears slot_cnt, row_cnt and loaded.
  - LOAD: busy=1.
- Beat accepted when in_valid && in_ready.
- Each accepted beat shifts the pack register left by D_WL and inserts in_data at the LSB slice. The first scalar of a row therefore ends in the MSB slice [UNITS_NUM*D_WL-1 -: D_WL], matching the bias ROM hex-literal order.
- Row completion: on the beat where slot_cnt==UNITS_NUM-1:
  - The full row ({pack[..] shifted, in_data}) is written to row row_cnt on that same edge.
  - slot_cnt resets to 0 and row_cnt increments.
  - No extra bubble; in_ready stays high.
- Load completion: on the row write where row_cnt==DEPTH-1:
  - Next cycle busy=0, in_ready=0, done=1 for exactly one cycle, loaded=1, FSM -> IDLE.
- in_valid while idle: ignored; no state change.
- start while busy: restart. Counters and pack register clear, already-written rows keep their contents, and the partial row is discarded. start has priority over a simultaneous beat, which is dropped.
- start in the same cycle as the final beat: the final row is written, then the restart takes effect. done does not pulse and loaded stays 0.
- Read port: combinational, w_o = row[addr] (zero latency).
  - addr >= DEPTH returns all zeros.
  - Read of the row being written in the same cycle returns the old contents; new data is visible after the edge.
- No arithmetic on data. Scalars are stored bit-exact, with no sign extension or saturation.

Optional Feature:
BO_RD_REG_EN:
- Defined: w_o is registered. It shows row[addr] one clock after addr is presented, resets to 0, and a write is visible on w_o two edges after the beat.
- Undefined: w_o is purely combinational as described above (drop-in for the ROM).

Test Plan:
- Reset then idle read: rst_n low, then addr=0..7 -> w_o=0 for all; busy=0, in_ready=0, loaded=0.
- Row pack order: start, then stream 000ee1, ffee0f, 000472, 00060f, fff950, then 25 more zero scalars -> addr=0 gives w_o='h000ee1ffee0f00047200060ffff950, done pulses exactly once 1 cycle after beat 30, loaded=1.
- Backpressure/gaps: same 30 scalars with in_valid toggled randomly -> identical row contents; no beats lost or duplicated; in_ready deasserts only after the 30th beat.
- Restart mid-load: start, 7 beats (row0 complete + 2), start again, 30 beats of value 'h000001 -> all rows = {5{24'h000001}}; only one done pulse.
- Out-of-range and same-cycle read: addr=6 and 255 -> 0. With addr=2 during the row-2 completing beat, w_o shows old value that cycle and new value next cycle.
- Reset mid-load: rst_n asserted after 12 beats -> all rows 0, busy=0, no done pulse. Under BO_RD_REG_EN, w_o lags addr by exactly 1 cycle.
